innerproduct_mac: RTL and testbench

- Parametrised, time-multiplexed successor to the fixed 81-tap combinational inner product.
- Accepts one flattened pixel window per transaction and computes hprime = sum(x[i]*theta[i]) over LANES products per cycle.
- Coefficients live in a run-time writable register bank instead of compile-time constants.
- Sits between the line-buffer window generator and the logistic (sigmoid/threshold) stage.

---
 rtl/innerproduct_pkg.sv | 43 ++++
 rtl/innerproduct_mac_tree.sv | 55 +++++
 rtl/innerproduct_mac.sv | 183 ++++++++++++++++++
 tb/tb_innerproduct_mac.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/innerproduct_pkg.sv
// =============================================================================
// Module   : innerproduct_pkg
// Purpose  : Shared state encoding and helpers for the inner-product MAC.
// Revision : 1.0
// =============================================================================
`default_nettype none

package innerproduct_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Widest internal accumulator the clamp helper supports.
    localparam int MAX_WIDE_W = 64;

    function automatic int beats(input int n, input int lanes);
        return (n + lanes - 1) / lanes;
    endfunction

    function automatic logic signed [MAX_WIDE_W-1:0] sat_clamp(
        input logic signed [MAX_WIDE_W-1:0] v,
        input int                           acc_w
    );
        logic signed [MAX_WIDE_W-1:0] one;
        logic signed [MAX_WIDE_W-1:0] hi;
        logic signed [MAX_WIDE_W-1:0] lo;
        one = 64'sd1;
        hi  = (one <<< (acc_w - 1)) - one;
        lo  = -hi - one;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/innerproduct_mac_tree.sv
// =============================================================================
// Module   : mac_lane_tree
// Purpose  : LANES parallel (unsigned pixel x signed coefficient) products
//            reduced by a balanced binary adder tree.
// Revision : 1.0
// =============================================================================
`default_nettype none

module mac_lane_tree #(
    parameter int LANES   = 9,
    parameter int X_W     = 7,
    parameter int THETA_W = 16,
    parameter int OUT_W   = 36
) (
    input  logic [LANES*X_W-1:0]     x_i,
    input  logic [LANES*THETA_W-1:0] theta_i,
    output logic signed [OUT_W-1:0]  psum_o
);

    localparam int PROD_W = X_W + THETA_W + 1;
    localparam int LEAVES = 1 << $clog2(LANES);

    logic signed [OUT_W-1:0] leaf [LEAVES];
    logic signed [OUT_W-1:0] node [LEAVES];

    for (genvar l = 0; l < LEAVES; l++) begin : g_leaf
        if (l < LANES) begin : g_mul
            logic signed [PROD_W-1:0]  prod;
            logic signed [THETA_W-1:0] theta_s;
            assign theta_s = theta_i[l*THETA_W +: THETA_W];
            // Pixel is zero-extended so it multiplies as a non-negative signed value.
            assign prod    = PROD_W'($signed({1'b0, x_i[l*X_W +: X_W]})) * PROD_W'(theta_s);
            assign leaf[l] = OUT_W'(prod);
        end else begin : g_pad
            assign leaf[l] = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < LEAVES; i++) begin
            node[i] = leaf[i];
        end
        // In-place pairwise reduction, one tree level per pass.
        for (int w = LEAVES / 2; w >= 1; w = w / 2) begin
            for (int i = 0; i < w; i++) begin
                node[i] = node[2*i] + node[2*i+1];
            end
        end
    end

    assign psum_o = node[0];

endmodule

`default_nettype wire

// File: rtl/innerproduct_mac.sv
// =============================================================================
// Module   : innerproduct_mac
// Purpose  : Time-multiplexed inner product of a pixel window with a writable
//            coefficient bank, LANES products per beat.
// Revision : 1.0
// =============================================================================
`default_nettype none

module innerproduct_mac
    import innerproduct_pkg::*;
#(
    parameter int N_TAPS   = 81,
    parameter int X_W      = 7,
    parameter int THETA_W  = 16,
    parameter int ACC_W    = 32,
    parameter int LANES    = 9,
    parameter int SATURATE = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_TAPS*X_W-1:0]       x_flat,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        coef_we,
    input  logic [$clog2(N_TAPS)-1:0]   coef_addr,
    input  logic signed [THETA_W-1:0]   coef_data,
    output logic                        coef_err,
    output logic signed [ACC_W-1:0]     hprime,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy
);

    localparam int BEATS  = beats(N_TAPS, LANES);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PROD_W = X_W + THETA_W + 1;
    // Internal widths never drop below one full product, so narrow ACC_W
    // settings still see the true sum before wrapping or clamping.
    localparam int BASE_W = (ACC_W > PROD_W) ? ACC_W : PROD_W;
    localparam int SUM_W  = BASE_W + $clog2(LANES);
    localparam int WIDE_W = BASE_W + $clog2(N_TAPS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_e                     state_q, state_d;
    logic signed [WIDE_W-1:0]   acc_q, acc_d;
    logic [BEAT_W-1:0]          beat_q, beat_d;
    logic signed [ACC_W-1:0]    hprime_q, hprime_d;
    logic                       in_ready_q, out_valid_q, busy_q;
    logic                       coef_err_q, coef_err_d;
    logic [N_TAPS*X_W-1:0]      win_q;
    logic signed [THETA_W-1:0]  coef_q [N_TAPS];

    logic                       start, addr_ok, coef_wr;
    logic signed [SUM_W-1:0]    psum;
    logic signed [WIDE_W-1:0]   acc_next;
    logic signed [ACC_W-1:0]    result;

    logic [LANES*X_W-1:0]       x_beat [BEATS];
    logic [LANES*THETA_W-1:0]   c_beat [BEATS];
    logic [LANES*X_W-1:0]       x_sel;
    logic [LANES*THETA_W-1:0]   c_sel;

    // Static tap-to-lane map; taps past N_TAPS become zero-weight padding.
    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            localparam int TAP = b * LANES + l;
            if (TAP < N_TAPS) begin : g_tap
                assign x_beat[b][l*X_W +: X_W]         = win_q[TAP*X_W +: X_W];
                assign c_beat[b][l*THETA_W +: THETA_W] = coef_q[TAP];
            end else begin : g_pad
                assign x_beat[b][l*X_W +: X_W]         = '0;
                assign c_beat[b][l*THETA_W +: THETA_W] = '0;
            end
        end
    end

    always_comb begin
        x_sel = '0;
        c_sel = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BEAT_W'(b)) begin
                x_sel = x_beat[b];
                c_sel = c_beat[b];
            end
        end
    end

    mac_lane_tree #(
        .LANES   (LANES),
        .X_W     (X_W),
        .THETA_W (THETA_W),
        .OUT_W   (SUM_W)
    ) u_tree (
        .x_i     (x_sel),
        .theta_i (c_sel),
        .psum_o  (psum)
    );

    assign acc_next = acc_q + WIDE_W'(psum);

    if (SATURATE != 0) begin : g_sat
        assign result = ACC_W'(sat_clamp(64'(acc_next), ACC_W));
    end else begin : g_wrap
        assign result = acc_next[ACC_W-1:0];
    end

    assign addr_ok    = (int'(coef_addr) < N_TAPS);
    assign coef_wr    = coef_we && (state_q == IDLE) && addr_ok;
    assign coef_err_d = coef_we && ((state_q != IDLE) || !addr_ok);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        beat_d   = beat_q;
        hprime_d = hprime_q;
        start    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    start   = 1'b1;
                    acc_d   = '0;
                    beat_d  = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d  = acc_next;
                beat_d = beat_q + BEAT_W'(1);
                if (beat_q == LAST_BEAT) begin
                    hprime_d = result;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            beat_q      <= '0;
            hprime_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            coef_err_q  <= 1'b0;
            win_q       <= '0;
            for (int i = 0; i < N_TAPS; i++) begin
                coef_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            beat_q      <= beat_d;
            hprime_q    <= hprime_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
            coef_err_q  <= coef_err_d;
            if (start) begin
                win_q <= x_flat;
            end
            if (coef_wr) begin
                coef_q[coef_addr] <= coef_data;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign coef_err  = coef_err_q;
    assign hprime    = hprime_q;

endmodule

`default_nettype wire

// File: tb/tb_innerproduct_mac.sv
// =============================================================================
// Module   : tb_innerproduct_mac
// Purpose  : Directed bench for innerproduct_mac across four parameter sets.
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_innerproduct_mac;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;
    int hs;
    int tmo;
    int seen;

    // Default configuration: 81 taps, 9 lanes, 32-bit wrap.
    logic [81*7-1:0]    m_x;
    logic               m_iv, m_ir, m_we, m_err, m_ov, m_or, m_busy;
    logic [6:0]         m_addr;
    logic [15:0]        m_data;
    logic signed [31:0] m_h;

    // Small configuration: 10 taps, 4 lanes (padded final beat).
    logic [10*7-1:0]    s_x;
    logic               s_iv, s_ir, s_we, s_err, s_ov, s_or, s_busy;
    logic [3:0]         s_addr;
    logic [15:0]        s_data;
    logic signed [31:0] s_h;

    // 16-bit result pair sharing one stimulus: clamp and wrap.
    logic [81*7-1:0]    o_x;
    logic               o_iv, o_we, o_or;
    logic [6:0]         o_addr;
    logic [15:0]        o_data;
    logic               sat_ir, sat_err, sat_ov, sat_busy;
    logic signed [15:0] sat_h;
    logic               wrp_ir, wrp_err, wrp_ov, wrp_busy;
    logic signed [15:0] wrp_h;

    innerproduct_mac u_main (
        .clk(clk), .rst(rst), .x_flat(m_x), .in_valid(m_iv), .in_ready(m_ir),
        .coef_we(m_we), .coef_addr(m_addr), .coef_data(m_data), .coef_err(m_err),
        .hprime(m_h), .out_valid(m_ov), .out_ready(m_or), .busy(m_busy)
    );

    innerproduct_mac #(.N_TAPS(10), .LANES(4)) u_small (
        .clk(clk), .rst(rst), .x_flat(s_x), .in_valid(s_iv), .in_ready(s_ir),
        .coef_we(s_we), .coef_addr(s_addr), .coef_data(s_data), .coef_err(s_err),
        .hprime(s_h), .out_valid(s_ov), .out_ready(s_or), .busy(s_busy)
    );

    innerproduct_mac #(.ACC_W(16), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .x_flat(o_x), .in_valid(o_iv), .in_ready(sat_ir),
        .coef_we(o_we), .coef_addr(o_addr), .coef_data(o_data), .coef_err(sat_err),
        .hprime(sat_h), .out_valid(sat_ov), .out_ready(o_or), .busy(sat_busy)
    );

    innerproduct_mac #(.ACC_W(16), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .x_flat(o_x), .in_valid(o_iv), .in_ready(wrp_ir),
        .coef_we(o_we), .coef_addr(o_addr), .coef_data(o_data), .coef_err(wrp_err),
        .hprime(wrp_h), .out_valid(wrp_ov), .out_ready(o_or), .busy(wrp_busy)
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // All tasks are entered on a falling edge and return on a falling edge.
    task automatic m_write(input int addr, input int data);
        m_we   = 1'b1;
        m_addr = 7'(addr);
        m_data = 16'(data);
        @(negedge clk);
        m_we   = 1'b0;
    endtask

    task automatic m_fill_x(input int v);
        for (int i = 0; i < 81; i++) m_x[i*7 +: 7] = 7'(v);
    endtask

    task automatic m_wait_result(input string tag, input int exp, input int hs_cyc);
        int k = 0;
        while (!m_ov && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_val({tag, "_valid"}, m_ov, 1);
        check_val({tag, "_latency"}, cyc - hs_cyc, 10);
        check_val({tag, "_hprime"}, m_h, exp);
    endtask

    task automatic m_pop();
        m_or = 1'b1;
        @(negedge clk);
        m_or = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        m_x  = '0; m_iv = 0; m_we = 0; m_addr = '0; m_data = '0; m_or = 0;
        s_x  = '0; s_iv = 0; s_we = 0; s_addr = '0; s_data = '0; s_or = 0;
        o_x  = '0; o_iv = 0; o_we = 0; o_addr = '0; o_data = '0; o_or = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check_val("rst_in_ready", m_ir, 1);
        check_val("rst_out_valid", m_ov, 0);
        check_val("rst_hprime", m_h, 0);
        check_val("rst_busy", m_busy, 0);
        check_val("rst_coef_err", m_err, 0);
        check_val("rst_small_ready", s_ir, 1);
        check_val("rst_wrap_ready", wrp_ir, 1);

        // All theta = 1, all x = 127
        for (int i = 0; i < 81; i++) m_write(i, 1);
        m_fill_x(127);
        hs = cyc; m_iv = 1'b1;
        @(negedge clk);
        m_iv = 1'b0;
        check_val("accum_busy", m_busy, 1);
        check_val("accum_in_ready", m_ir, 0);
        m_wait_result("basic", 10287, hs);

        // Backpressure with a new window already offered
        m_fill_x(1);
        m_iv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("bp_valid_hold", m_ov, 1);
            check_val("bp_hprime_hold", m_h, 10287);
            check_val("bp_in_ready", m_ir, 0);
        end
        m_or = 1'b1;
        @(negedge clk);
        m_or = 1'b0;
        check_val("bp_release_valid", m_ov, 0);
        check_val("bp_release_ready", m_ir, 1);
        check_val("bp_hprime_kept", m_h, 10287);
        hs = cyc;
        @(negedge clk);
        m_iv = 1'b0;
        m_fill_x(99);  // window already captured, must not matter
        check_val("bp_accepted_busy", m_busy, 1);
        m_wait_result("bp_next", 81, hs);
        m_pop();

        // Write attempt during ACCUM is rejected
        for (int i = 0; i < 81; i++) m_x[i*7 +: 7] = 7'(i);
        hs = cyc; m_iv = 1'b1;
        @(negedge clk);
        m_iv = 1'b0;
        m_we = 1'b1; m_addr = 7'd5; m_data = 16'd100;
        @(negedge clk);
        m_we = 1'b0;
        check_val("accum_write_err", m_err, 1);
        @(negedge clk);
        check_val("accum_write_err_pulse", m_err, 0);
        m_wait_result("accum_write", 3240, hs);
        m_pop();

        // Out-of-range address in IDLE
        m_we = 1'b1; m_addr = 7'd81; m_data = 16'd7;
        @(negedge clk);
        m_we = 1'b0;
        check_val("bad_addr_err", m_err, 1);

        // theta[0] = 5 written in the handshake cycle
        m_fill_x(127);
        m_we = 1'b1; m_addr = 7'd0; m_data = 16'd5;
        hs = cyc; m_iv = 1'b1;
        @(negedge clk);
        m_we = 1'b0; m_iv = 1'b0;
        check_val("hs_write_no_err", m_err, 0);
        m_wait_result("hs_write", 10795, hs);
        m_pop();

        // Signed coefficients with padded lanes: 10 taps, 4 lanes
        for (int i = 0; i < 10; i++) begin
            s_we = 1'b1; s_addr = 4'(i); s_data = 16'(-(i + 1));
            @(negedge clk);
        end
        s_we = 1'b0;
        for (int i = 0; i < 10; i++) s_x[i*7 +: 7] = 7'd2;
        hs = cyc; s_iv = 1'b1;
        @(negedge clk);
        s_iv = 1'b0;
        tmo = 0;
        while (!s_ov && tmo < 20) begin
            @(negedge clk);
            tmo++;
        end
        check_val("small_valid", s_ov, 1);
        check_val("small_latency", cyc - hs, 4);
        check_val("small_hprime", s_h, -110);
        check_val("small_busy", s_busy, 1);
        check_val("small_err", s_err, 0);
        s_or = 1'b1;
        @(negedge clk);
        s_or = 1'b0;

        // Overflow at ACC_W = 16
        for (int i = 0; i < 81; i++) begin
            o_we = 1'b1; o_addr = 7'(i); o_data = 16'd32767;
            @(negedge clk);
        end
        o_we = 1'b0;
        for (int i = 0; i < 81; i++) o_x[i*7 +: 7] = 7'd127;
        hs = cyc; o_iv = 1'b1;
        @(negedge clk);
        o_iv = 1'b0;
        tmo = 0;
        while (!sat_ov && tmo < 40) begin
            @(negedge clk);
            tmo++;
        end
        check_val("sat_valid", sat_ov, 1);
        check_val("sat_latency", cyc - hs, 10);
        check_val("sat_hprime", sat_h, 32767);
        check_val("wrap_valid", wrp_ov, 1);
        check_val("wrap_hprime", wrp_h, 22481);
        check_val("ovf_busy", sat_busy & wrp_busy, 1);
        check_val("ovf_err", sat_err | wrp_err, 0);
        check_val("ovf_ready", sat_ir | wrp_ir, 0);
        o_or = 1'b1;
        @(negedge clk);
        o_or = 1'b0;

        // Reset held two cycles mid-ACCUM
        m_fill_x(127);
        m_iv = 1'b1;
        @(negedge clk);
        m_iv = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("midrst_out_valid", m_ov, 0);
        check_val("midrst_hprime", m_h, 0);
        check_val("midrst_in_ready", m_ir, 1);
        check_val("midrst_busy", m_busy, 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (m_ov) seen++;
        end
        check_val("midrst_no_result", seen, 0);

        // Coefficients were cleared by reset
        hs = cyc; m_iv = 1'b1;
        @(negedge clk);
        m_iv = 1'b0;
        m_wait_result("cleared_coef", 0, hs);
        m_pop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
